// File: rtl/reg_3r1w_pkg.sv
// reg_3r1w_pkg: shared constants and types for the 3-read/1-write register file.
// Defaults here size the GPR storage used by the fixed-point pipeline.
package reg_3r1w_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/reg_3r1w_rdport.sv
// reg_3r1w_rdport: one registered-address read port.
// Address latches on enable; data is muxed combinationally from the array.
module reg_3r1w_rdport #(
    parameter int DW = reg_3r1w_pkg::DW,
    parameter int AW = reg_3r1w_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] mem [2**AW],
    output logic [DW-1:0] rd_do
);

    logic [AW-1:0] addr_q;

    // latch the requested address; hold it while the port is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (en) begin
            addr_q <= addr;
        end
    end

    assign rd_do = mem[addr_q];

endmodule

// File: rtl/reg_3r1w_generic.sv
// reg_3r1w_generic: 2**AW x DW flip-flop register file, 3 read ports, 1 write.
// Define REG_3R1W_RST_CLEAR_EN to make reset also zero every entry.
module reg_3r1w_generic #(
    parameter int DW = reg_3r1w_pkg::DW,
    parameter int AW = reg_3r1w_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rda_en,
    input  logic [AW-1:0] rda_addr,
    output logic [DW-1:0] rda_do,
    input  logic          rdb_en,
    input  logic [AW-1:0] rdb_addr,
    output logic [DW-1:0] rdb_do,
    input  logic          rdc_en,
    input  logic [AW-1:0] rdc_addr,
    output logic [DW-1:0] rdc_do,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

`ifdef REG_3R1W_RST_CLEAR_EN
    // storage with clear-on-reset; reset wins over a same-edge write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end
`else
    // storage left uninitialised so it can map to RAM; reset blocks writes
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end
`endif

    reg_3r1w_rdport #(.DW(DW), .AW(AW)) u_rda (
        .clk   (clk),
        .rst   (rst),
        .en    (rda_en),
        .addr  (rda_addr),
        .mem   (mem),
        .rd_do (rda_do)
    );

    reg_3r1w_rdport #(.DW(DW), .AW(AW)) u_rdb (
        .clk   (clk),
        .rst   (rst),
        .en    (rdb_en),
        .addr  (rdb_addr),
        .mem   (mem),
        .rd_do (rdb_do)
    );

    reg_3r1w_rdport #(.DW(DW), .AW(AW)) u_rdc (
        .clk   (clk),
        .rst   (rst),
        .en    (rdc_en),
        .addr  (rdc_addr),
        .mem   (mem),
        .rd_do (rdc_do)
    );

endmodule

// File: tb/tb_reg_3r1w_generic.sv
// tb_reg_3r1w_generic: directed and randomized checks of reg_3r1w_generic.
// Reference is a plain array plus three latched addresses.
module tb_reg_3r1w_generic;
    import reg_3r1w_pkg::*;

    logic  clk;
    logic  rst;
    logic  rda_en, rdb_en, rdc_en, wr_en;
    addr_t rda_addr, rdb_addr, rdc_addr, wr_addr;
    word_t rda_do, rdb_do, rdc_do, wr_data;

    word_t m_mem   [DEPTH];
    bit    m_known [DEPTH];
    addr_t m_a, m_b, m_c;

    int n_cmp;
    int n_bad;

    reg_3r1w_generic dut (
        .clk      (clk),
        .rst      (rst),
        .rda_en   (rda_en),
        .rda_addr (rda_addr),
        .rda_do   (rda_do),
        .rdb_en   (rdb_en),
        .rdb_addr (rdb_addr),
        .rdb_do   (rdb_do),
        .rdc_en   (rdc_en),
        .rdc_addr (rdc_addr),
        .rdc_do   (rdc_do),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst      = 1'b0;
        rda_en   = 1'b0;
        rdb_en   = 1'b0;
        rdc_en   = 1'b0;
        wr_en    = 1'b0;
    endtask

    // one clock edge: update the reference, then compare every port
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_a = '0;
            m_b = '0;
            m_c = '0;
`ifdef REG_3R1W_RST_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]   = '0;
                m_known[i] = 1'b1;
            end
`endif
        end else begin
            if (wr_en) begin
                m_mem[wr_addr]   = wr_data;
                m_known[wr_addr] = 1'b1;
            end
            if (rda_en) m_a = rda_addr;
            if (rdb_en) m_b = rdb_addr;
            if (rdc_en) m_c = rdc_addr;
        end
        #1;
        if (m_known[m_a]) check("port_a", rda_do, m_mem[m_a]);
        if (m_known[m_b]) check("port_b", rdb_do, m_mem[m_b]);
        if (m_known[m_c]) check("port_c", rdc_do, m_mem[m_c]);
    endtask

    task automatic wr(input addr_t a, input word_t d);
        idle();
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        m_a = '0;
        m_b = '0;
        m_c = '0;
        idle();
        rda_addr = '0;
        rdb_addr = '0;
        rdc_addr = '0;
        wr_addr  = '0;
        wr_data  = '0;

        // reset for two cycles
        rst = 1'b1;
        tick();
        tick();
        idle();
`ifdef REG_3R1W_RST_CLEAR_EN
        check("rst_a", rda_do, 32'h0);
        check("rst_b", rdb_do, 32'h0);
        check("rst_c", rdc_do, 32'h0);
        for (int i = 0; i < DEPTH; i += 7) begin
            rda_en   = 1'b1;
            rda_addr = addr_t'(i);
            tick();
            check("rst_clr", rda_do, 32'h0);
        end
        idle();
`endif

        // give every entry a known value
        for (int i = 0; i < DEPTH; i++) begin
            wr(addr_t'(i), $urandom);
        end

        // write then read
        wr(5, 32'hDEADBEEF);
        rda_en   = 1'b1;
        rda_addr = 5;
        tick();
        check("wr_rd", rda_do, 32'hDEADBEEF);
        idle();

        // three independent ports
        wr(1, 32'h11);
        wr(2, 32'h22);
        wr(3, 32'h33);
        rda_en = 1'b1; rda_addr = 1;
        rdb_en = 1'b1; rdb_addr = 2;
        rdc_en = 1'b1; rdc_addr = 3;
        tick();
        check("tri_a", rda_do, 32'h11);
        check("tri_b", rdb_do, 32'h22);
        check("tri_c", rdc_do, 32'h33);
        rda_addr = 7;
        rdb_addr = 7;
        rdc_addr = 7;
        tick();
        check("same_ab", rda_do, rdb_do);
        check("same_ac", rda_do, rdc_do);
        check("same_7", rda_do, m_mem[7]);
        idle();

        // hold while disabled, then observe rewrite of held entry
        wr(4, 32'h44);
        rda_en   = 1'b1;
        rda_addr = 4;
        tick();
        rda_en   = 1'b0;
        rda_addr = 9;
        tick();
        check("hold", rda_do, 32'h44);
        wr(4, 32'h55);
        check("hold_upd", rda_do, 32'h55);

        // write-first on same-edge conflict
        wr(8, 32'hAA);
        wr_en    = 1'b1;
        wr_addr  = 8;
        wr_data  = 32'hBB;
        rdb_en   = 1'b1;
        rdb_addr = 8;
        tick();
        check("wfirst", rdb_do, 32'hBB);
        idle();

        // reset overrides a same-edge write and read enables
        wr(0, 32'h0000_00F0);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 6;
        wr_data = 32'h66;
        rda_en  = 1'b1;
        rda_addr = 6;
        tick();
        idle();
`ifdef REG_3R1W_RST_CLEAR_EN
        check("rst_mid_a", rda_do, 32'h0);
`else
        check("rst_mid_a", rda_do, 32'hF0);
        check("rst_mid_c", rdc_do, 32'hF0);
`endif
        rdb_en   = 1'b1;
        rdb_addr = 6;
        tick();
        check("rst_mid_m6", rdb_do, m_mem[6]);
        if (rdb_do === 32'h66) check("rst_no_wr", rdb_do, m_mem[6]);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_known[i]) wr(addr_t'(i), $urandom);
        end

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 60) == 0);
            wr_en    = $urandom_range(0, 1);
            wr_addr  = addr_t'($urandom);
            wr_data  = $urandom;
            rda_en   = $urandom_range(0, 1);
            rdb_en   = $urandom_range(0, 1);
            rdc_en   = $urandom_range(0, 1);
            rda_addr = addr_t'($urandom);
            rdb_addr = ($urandom_range(0, 3) == 0) ? wr_addr
                                                   : addr_t'($urandom);
            rdc_addr = ($urandom_range(0, 3) == 0) ? rda_addr
                                                   : addr_t'($urandom);
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
